// File: rtl/universal_ff_bank.sv
// universal_ff_bank -- a bank of WIDTH flip-flops that behave as SR, JK, D or
// T flip-flops, selected per cycle by 'mode'. It also tracks SR S=R=1 misuse.
//
// Parameters
//   WIDTH        number of flip-flop bits (1..32)
//   SR11_POLICY  SR-mode S=R=1 result: 0 hold, 1 set-dominant, 2 reset-dominant
//   PRESET_VAL   value loaded into q by 'preset'
//
// Ports
//   clk          rising-edge clock for all state
//   clr          synchronous active-high reset (highest priority)
//   preset       synchronous load of PRESET_VAL (second priority)
//   en           update enable for the mode operation; 0 holds every bit
//   mode         00 SR, 01 JK, 10 D, 11 T
//   a            S / J / D / T input, one bit per flip-flop
//   b            R / K input, one bit per flip-flop (ignored in D and T)
//   q, qbar      registered state and its registered complement
//   chg          high for one cycle after any q bit changed
//   illegal      sticky flag, set by an SR-mode S=R=1 cycle, cleared by clr
//   illegal_cnt  saturating count of SR-mode S=R=1 cycles, cleared by clr

`timescale 1ns/1ps

module universal_ff_bank #(
  parameter int              WIDTH       = 8,
  parameter int              SR11_POLICY = 0,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             preset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             chg,
  output logic             illegal,
  output logic [7:0]       illegal_cnt
);

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] sr_set;    // S=1, R=0
  logic [WIDTH-1:0] sr_rst;    // S=0, R=1
  logic [WIDTH-1:0] sr_both;   // S=1, R=1
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] jk_next;
  logic [WIDTH-1:0] next_q;
  logic             sr11_event;

  assign sr_set  = a & ~b;
  assign sr_rst  = ~a & b;
  assign sr_both = a & b;

  // S=R=1 bits resolve to a defined value under every policy, so q never
  // picks up an X from an ambiguous SR pattern.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    sr_next = (q | sr_set) & ~sr_rst;
    if (SR11_POLICY == 1) begin
      sr_next = sr_next | sr_both;
    end else if (SR11_POLICY == 2) begin
      sr_next = sr_next & ~sr_both;
    end
  end

  // JK: 00 hold, 10 set, 01 clear, 11 toggle.
  assign jk_next = (a & ~q) | (~b & q);

  // Whole-bank next state with the full priority chain folded in, so chg can be
  // a plain compare of next_q against q (clr and preset included).
  always_comb begin
    next_q = q;
    if (clr) begin
      next_q = '0;
    end else if (preset) begin
      next_q = PRESET_VAL;
    end else if (en) begin
      unique case (mode_e'(mode))
        MODE_SR: next_q = sr_next;
        MODE_JK: next_q = jk_next;
        MODE_D:  next_q = a;
        MODE_T:  next_q = q ^ a;
      endcase
    end
  end

  // One event per cycle, however many bits have S=R=1.
  assign sr11_event = !clr && !preset && en && (mode_e'(mode) == MODE_SR) && (|sr_both);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    q    <= next_q;
    qbar <= ~next_q;
    chg  <= (next_q != q);
    if (clr) begin
      illegal     <= 1'b0;
      illegal_cnt <= 8'd0;
    end else if (sr11_event) begin
      illegal <= 1'b1;
      if (illegal_cnt != 8'hFF) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/universal_ff_bank.md
UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of flip-flop bits (legal range 1..32).
REQ-002 The block SHALL have parameter SR11_POLICY, default 0, setting the SR-mode S=R=1 result: 0 hold, 1 set-dominant, 2 reset-dominant.
REQ-003 The block SHALL have parameter PRESET_VAL, default all-ones (WIDTH bits), giving the value q loads on preset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port preset, input, 1 bit: synchronous load of PRESET_VAL.
REQ-007 The block SHALL have port en, input, 1 bit: update enable for mode operations.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 SR, 01 JK, 10 D, 11 T.
REQ-009 The block SHALL have port a, input, WIDTH bits: S, J, D or T per bit, depending on mode.
REQ-010 The block SHALL have port b, input, WIDTH bits: R or K per bit; ignored in D and T modes.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-012 The block SHALL have port qbar, output, WIDTH bits: registered complement of q.
REQ-013 The block SHALL have port chg, output, 1 bit: one-cycle pulse, high in the cycle after any q bit changed value.
REQ-014 The block SHALL have port illegal, output, 1 bit: sticky flag, set by an SR-mode S=R=1 event.
REQ-015 The block SHALL have port illegal_cnt, output, 8 bits: saturating count of cycles containing an SR-mode S=R=1 event.

Function
REQ-016 Per-edge priority SHALL be: clr, then preset, then en=0 (hold all bits), then the mode operation.
REQ-017 In SR mode, each bit SHALL follow: 00 hold, 10 set, 01 clear, 11 per SR11_POLICY; q SHALL never be driven to X.
REQ-018 In JK mode, each bit SHALL follow: 00 hold, 10 set, 01 clear, 11 toggle.
REQ-019 In D mode, q SHALL load a; b is ignored.
REQ-020 In T mode, q SHALL become q XOR a; b is ignored.
REQ-021 All bits SHALL update in the same edge (latency 1 cycle, input to q).
REQ-022 qbar SHALL equal ~q at every clock edge, including reset and preset.
REQ-023 A cycle SHALL count as an SR11 event when clr=0, preset=0, en=1, mode=00, and (a AND b) is non-zero.
REQ-024 On an SR11 event, illegal SHALL be set to 1 and illegal_cnt SHALL increment by exactly 1, regardless of how many bits are 11, saturating at 255.
REQ-025 illegal SHALL remain set until clr.
REQ-026 preset SHALL NOT modify illegal or illegal_cnt.
REQ-027 chg SHALL be registered as (next_q != q), evaluated at the same edge that updates q.
REQ-028 chg SHALL be 1 after preset or after clr only if q actually changed.
REQ-029 Simultaneous clr and preset SHALL produce the clr result.
REQ-030 A mode change SHALL take effect at the same edge it is sampled, with no pipeline state carried between modes.
REQ-031 When en=0, an SR-mode a/b pattern SHALL NOT count as an SR11 event.

Reset
REQ-032 When clr=1 at a rising edge, the block SHALL set q=0, qbar all-ones, illegal=0, illegal_cnt=0; chg SHALL be 1 if q was non-zero, else 0.
REQ-033 clr asserted mid-operation (any mode, any en) SHALL override that cycle's operation completely.
REQ-034 Before the first clr, output values SHALL be unspecified; the bench SHALL apply clr for at least 1 cycle first.

Verification (WIDTH=8, PRESET_VAL=8'hFF)
REQ-035 Sequence clr; SR mode, en=1, a=8'h0F, b=8'h00; then a=8'h00, b=8'h03 -> q=8'h0F then 8'h0C, qbar=8'hF0 then 8'hF3, chg=1 both cycles.
REQ-036 SR11_POLICY=0, q=8'h0C, SR mode, a=8'h05, b=8'h04 -> q=8'h0D, illegal=1, illegal_cnt=1; policy 1 -> q=8'h0D; policy 2 -> q=8'h09.
REQ-037 q=8'h0C, JK mode, a=8'hFF, b=8'hFF -> q=8'hF3; T mode, a=8'h81 -> q=8'h72; D mode, a=8'h55, b=8'hAA -> q=8'h55.
REQ-038 300 consecutive SR11-event cycles -> illegal_cnt stops at 255; preset -> q=8'hFF, illegal_cnt stays 255; then clr -> illegal_cnt=0, illegal=0, q=8'h00.
REQ-039 clr=1 and preset=1 together -> q=8'h00; en=0 with JK a=b=8'hFF -> q unchanged, chg=0.
REQ-040 D mode, a=q, en=1 -> chg=0; then a=q^8'h01 -> chg=1 for exactly one cycle.
